// File: rtl/rf_wb_sched_pkg.sv
// Shared CPU package: register-file write-back defaults and the MDU hold FSM state type.
package rf_wb_sched_pkg;

    localparam int unsigned RF_DW_DEF         = 32;
    localparam int unsigned RF_AW_DEF         = 5;
    localparam int unsigned RF_STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        HOLD_EMPTY   = 2'd0,
        HOLD_FULL    = 2'd1,
        HOLD_STARVED = 2'd2
    } hold_state_e;

endpackage

// File: rtl/rf_wb_sched_scoreboard.sv
// Busy scoreboard for pending MDU destinations plus the RAW/WAW hazard check for decode.
module rf_scoreboard
    import rf_wb_sched_pkg::*;
#(
    parameter int AW = RF_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_rw,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_rw,
    input  logic [AW-1:0]     chk_ra,
    input  logic [AW-1:0]     chk_rb,
    input  logic [AW-1:0]     chk_rw,
    input  logic              chk_we,
    output logic [2**AW-1:0]  busy_mask,
    output logic              hazard
);

    localparam int NR = 2**AW;

    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_d;
    logic [NR-1:0] busy_vis;

    // The clear is visible in the drain cycle itself; a same-cycle set on the same bit wins.
    always_comb begin
        busy_vis = busy_q;
        if (clr_en) begin
            busy_vis[clr_rw] = 1'b0;
        end
        busy_d = busy_vis;
        if (set_en) begin
            busy_d[set_rw] = 1'b1;
        end
    end

    always_comb begin
        hazard = ((chk_ra != '0) && busy_vis[chk_ra]) ||
                 ((chk_rb != '0) && busy_vis[chk_rb]) ||
                 (chk_we && (chk_rw != '0) && busy_vis[chk_rw]);
    end

    assign busy_mask = busy_vis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-back scheduler: pipeline WB has priority, one MDU result is held until a free port.
// Optional starvation guard (wait counter + STARVED state) enabled by defining RF_WB_STARVE_GUARD_EN.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int DW         = RF_DW_DEF,
    parameter int AW         = RF_AW_DEF,
    parameter int STARVE_MAX = RF_STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_ra,
    input  logic [AW-1:0]     issue_rb,
    input  logic [AW-1:0]     issue_rw,
    input  logic              issue_we,
    input  logic              issue_long,
    output logic              issue_stall,
    input  logic              pipe_we,
    input  logic [AW-1:0]     pipe_rw,
    input  logic [DW-1:0]     pipe_wd,
    input  logic              mdu_valid,
    input  logic [AW-1:0]     mdu_rw,
    input  logic [DW-1:0]     mdu_wd,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [AW-1:0]     rf_rw,
    output logic [DW-1:0]     rf_busw,
    output logic [2**AW-1:0]  busy_mask
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("rf_wb_sched: STARVE_MAX must be at least 1");
    end

    hold_state_e   state_q, state_d;
    logic [AW-1:0] hold_rw_q, hold_rw_d;
    logic [DW-1:0] hold_wd_q, hold_wd_d;

    logic pipe_wr;
    logic hold_full;
    logic drain;
    logic hold_wr;
    logic mdu_acc;
    logic issue_acc;
    logic sb_set;
    logic hazard;

    assign pipe_wr   = pipe_we && (pipe_rw != '0);
    assign hold_full = (state_q != HOLD_EMPTY);
    assign drain     = hold_full && !pipe_wr;
    // A result aimed at r0 still empties the hold but never reaches the register file.
    assign hold_wr   = drain && (hold_rw_q != '0);
    assign mdu_ready = (state_q == HOLD_EMPTY);
    assign mdu_acc   = mdu_valid && mdu_ready;

    assign rf_we   = pipe_wr || hold_wr;
    assign rf_rw   = pipe_wr ? pipe_rw : hold_rw_q;
    assign rf_busw = pipe_wr ? pipe_wd : hold_wd_q;

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] wait_q, wait_d;

    // Counts FULL cycles in which the pipeline took the port; saturates, cleared on drain.
    always_comb begin
        wait_d = wait_q;
        if (drain) begin
            wait_d = '0;
        end else if ((state_q == HOLD_FULL) && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign issue_stall = (issue_valid && hazard) || (state_q == HOLD_STARVED);
`else
    assign issue_stall = issue_valid && hazard;
`endif

    assign issue_acc = issue_valid && !issue_stall;
    assign sb_set    = issue_acc && issue_long && issue_we && (issue_rw != '0);

    always_comb begin
        state_d   = state_q;
        hold_rw_d = hold_rw_q;
        hold_wd_d = hold_wd_q;
        case (state_q)
            HOLD_EMPTY: begin
                if (mdu_acc) begin
                    state_d   = HOLD_FULL;
                    hold_rw_d = mdu_rw;
                    hold_wd_d = mdu_wd;
                end
            end
            HOLD_FULL: begin
                if (drain) begin
                    state_d = HOLD_EMPTY;
`ifdef RF_WB_STARVE_GUARD_EN
                end else if (wait_d == WAIT_MAX) begin
                    state_d = HOLD_STARVED;
`endif
                end
            end
            HOLD_STARVED: begin
                if (drain) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HOLD_EMPTY;
            hold_rw_q <= '0;
            hold_wd_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_rw_q <= hold_rw_d;
            hold_wd_q <= hold_wd_d;
        end
    end

    rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_en    (sb_set),
        .set_rw    (issue_rw),
        .clr_en    (hold_wr),
        .clr_rw    (hold_rw_q),
        .chk_ra    (issue_ra),
        .chk_rb    (issue_rb),
        .chk_rw    (issue_rw),
        .chk_we    (issue_we),
        .busy_mask (busy_mask),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: write-back order checked through an expected-write queue.
module tb_rf_wb_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2**AW;
`ifdef RF_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid;
    logic [AW-1:0] issue_ra, issue_rb, issue_rw;
    logic          issue_we, issue_long;
    logic          issue_stall;
    logic          pipe_we;
    logic [AW-1:0] pipe_rw;
    logic [DW-1:0] pipe_wd;
    logic          mdu_valid;
    logic [AW-1:0] mdu_rw;
    logic [DW-1:0] mdu_wd;
    logic          mdu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_busw;
    logic [NR-1:0] busy_mask;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    rf_wb_sched #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_ra    (issue_ra),
        .issue_rb    (issue_rb),
        .issue_rw    (issue_rw),
        .issue_we    (issue_we),
        .issue_long  (issue_long),
        .issue_stall (issue_stall),
        .pipe_we     (pipe_we),
        .pipe_rw     (pipe_rw),
        .pipe_wd     (pipe_wd),
        .mdu_valid   (mdu_valid),
        .mdu_rw      (mdu_rw),
        .mdu_wd      (mdu_wd),
        .mdu_ready   (mdu_ready),
        .rf_we       (rf_we),
        .rf_rw       (rf_rw),
        .rf_busw     (rf_busw),
        .busy_mask   (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_ra = '0; issue_rb = '0; issue_rw = '0;
        issue_we = 0; issue_long = 0;
        pipe_we = 0; pipe_rw = '0; pipe_wd = '0;
        mdu_valid = 0; mdu_rw = '0; mdu_wd = '0;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rw, input logic we, input logic lng);
        issue_valid = v; issue_ra = ra; issue_rb = rb; issue_rw = rw;
        issue_we = we; issue_long = lng;
    endtask

    task automatic pipe(input logic we, input logic [AW-1:0] rw, input logic [DW-1:0] wd);
        pipe_we = we; pipe_rw = rw; pipe_wd = wd;
    endtask

    task automatic mdu(input logic v, input logic [AW-1:0] rw, input logic [DW-1:0] wd);
        mdu_valid = v; mdu_rw = rw; mdu_wd = wd;
    endtask

    task automatic expect_wr(input logic [AW-1:0] rw, input logic [DW-1:0] wd);
        wr_t w;
        w.rw = rw;
        w.wd = wd;
        exp_q.push_back(w);
    endtask

    // Every register-file write is matched against the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_we", rf_we, 1'b0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wb_rw", rf_rw, w.rw);
                chk("wb_wd", rf_busw, w.wd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy_mask", busy_mask, '0);
        chk("rst_mdu_ready", mdu_ready, 1'b1);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_issue_stall", issue_stall, 1'b0);
        reset_n = 1'b1;
        cyc();

        // Long op to r5, dependent reads stall until the MDU result is written
        issue(1, 5'd1, 5'd2, 5'd5, 1, 1);
        #1 chk("a_issue_free", issue_stall, 1'b0);
        cyc();
        issue(1, 5'd5, 5'd0, 5'd0, 0, 0);
        #1 chk("a_busy5_set", busy_mask[5], 1'b1);
        chk("a_raw_stall", issue_stall, 1'b1);
        issue(1, 5'd0, 5'd0, 5'd5, 1, 0);
        #1 chk("a_waw_stall", issue_stall, 1'b1);
        issue(1, 5'd5, 5'd0, 5'd0, 0, 0);
        mdu(1, 5'd5, 32'h1234_5678);
        expect_wr(5'd5, 32'h1234_5678);
        #1 chk("a_mdu_ready", mdu_ready, 1'b1);
        chk("a_stall_on_accept", issue_stall, 1'b1);
        cyc();
        mdu(0, '0, '0);
        #1 chk("a_drain_we", rf_we, 1'b1);
        chk("a_drain_rw", rf_rw, 5'd5);
        chk("a_busy5_clear", busy_mask[5], 1'b0);
        chk("a_stall_release", issue_stall, 1'b0);
        chk("a_ready_in_drain", mdu_ready, 1'b0);
        cyc();
        idle();
        #1 chk("a_ready_after", mdu_ready, 1'b1);
        chk("a_idle_we", rf_we, 1'b0);
        chk("a_busy_empty", busy_mask, '0);

        // MDU offer collides with pipeline writes; the hold waits, then one-cycle turnaround
        mdu(1, 5'd7, 32'hAAAA_5555);
        pipe(1, 5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        #1 chk("b_pipe_first_rw", rf_rw, 5'd3);
        chk("b_ready_accept", mdu_ready, 1'b1);
        cyc();
        mdu(0, '0, '0);
        pipe(1, 5'd4, 32'h44);
        expect_wr(5'd4, 32'h44);
        #1 chk("b_ready_held", mdu_ready, 1'b0);
        chk("b_pipe_second_rw", rf_rw, 5'd4);
        cyc();
        pipe(0, '0, '0);
        mdu(1, 5'd8, 32'h88);
        expect_wr(5'd7, 32'hAAAA_5555);
        #1 chk("b_hold_rw", rf_rw, 5'd7);
        chk("b_hold_wd", rf_busw, 32'hAAAA_5555);
        chk("b_no_accept_in_drain", mdu_ready, 1'b0);
        cyc();
        expect_wr(5'd8, 32'h88);
        #1 chk("b_turnaround_ready", mdu_ready, 1'b1);
        cyc();
        mdu(0, '0, '0);
        #1 chk("b_turnaround_rw", rf_rw, 5'd8);
        cyc();
        idle();

        // Hold starved by ten back-to-back pipeline writes
        mdu(1, 5'd9, 32'h99);
        #1 chk("c_accept", mdu_ready, 1'b1);
        cyc();
        mdu(0, '0, '0);
        issue(1, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            pipe(1, AW'(10 + i), DW'(32'h100 + i));
            expect_wr(AW'(10 + i), DW'(32'h100 + i));
            #1 chk("c_starve_stall", issue_stall, GUARD && (i >= 4));
            chk("c_ready_held", mdu_ready, 1'b0);
            cyc();
        end
        pipe(0, '0, '0);
        expect_wr(5'd9, 32'h99);
        #1 chk("c_drain_rw", rf_rw, 5'd9);
        chk("c_drain_stall", issue_stall, GUARD);
        cyc();
        #1 chk("c_stall_cleared", issue_stall, 1'b0);
        chk("c_ready_after", mdu_ready, 1'b1);
        idle();

        // Pipeline write to r0 frees the port for the hold; long op to r0 sets nothing
        mdu(1, 5'd11, 32'hBB);
        pipe(1, 5'd12, 32'hCC);
        expect_wr(5'd12, 32'hCC);
        cyc();
        mdu(0, '0, '0);
        pipe(1, 5'd0, 32'hDEAD);
        expect_wr(5'd11, 32'hBB);
        #1 chk("d_r0_hold_we", rf_we, 1'b1);
        chk("d_r0_hold_rw", rf_rw, 5'd11);
        cyc();
        #1 chk("d_r0_no_write", rf_we, 1'b0);
        pipe(0, '0, '0);
        issue(1, 5'd0, 5'd0, 5'd0, 1, 1);
        #1 chk("d_r0_issue_free", issue_stall, 1'b0);
        cyc();
        idle();
        #1 chk("d_r0_busy_unchanged", busy_mask, '0);

        // Reset with a full hold and r9 pending
        issue(1, 5'd0, 5'd0, 5'd9, 1, 1);
        cyc();
        idle();
        #1 chk("e_busy9_set", busy_mask[9], 1'b1);
        mdu(1, 5'd9, 32'h9999);
        pipe(1, 5'd13, 32'hD);
        expect_wr(5'd13, 32'hD);
        cyc();
        idle();
        #1 chk("e_hold_full", mdu_ready, 1'b0);
        reset_n = 1'b0;
        #1 chk("e_rst_busy", busy_mask, '0);
        chk("e_rst_ready", mdu_ready, 1'b1);
        chk("e_rst_we", rf_we, 1'b0);
        chk("e_rst_stall", issue_stall, 1'b0);
        repeat (2) cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1 chk("e_post_reset_idle", rf_we, 1'b0);
        end

        cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 SHALL have parameter DW, default 32: write-data width.
REQ-002 SHALL have parameter AW, default 5: register-address width (2**AW registers, r0 hard-wired zero).
REQ-003 SHALL have parameter STARVE_MAX, default 4: cycles a held MDU result may wait before a forced bubble.
REQ-004 SHALL have ports:
  clk  in  1  clock, all state on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  issue_valid  in  1  instruction in decode wants to issue.
  issue_ra, issue_rb, issue_rw  in  AW  source and destination registers.
  issue_we  in  1  instruction writes issue_rw.
  issue_long  in  1  instruction is a multi-cycle MDU op.
  issue_stall  out  1  hold decode this cycle.
  pipe_we  in  1  pipeline WB write request (cannot be back-pressured).
  pipe_rw  in  AW, pipe_wd  in  DW  pipeline WB address/data.
  mdu_valid  in  1, mdu_rw  in  AW, mdu_wd  in  DW  MDU result offer.
  mdu_ready  out  1  MDU result accepted when mdu_valid & mdu_ready.
  rf_we  out  1, rf_rw  out  AW, rf_busw  out  DW  register-file write port.
  busy_mask  out  2**AW  scoreboard, bit n = MDU write to rn pending.

Function
REQ-005 SHALL accept an issue when issue_valid & !issue_stall.
REQ-006 SHALL set busy_mask[issue_rw] on an accepted issue with issue_long & issue_we & issue_rw!=0.
REQ-007 SHALL clear busy_mask[rw] in the cycle the held MDU result is written to the register file; if set and clear target the same bit in one cycle, set wins.
REQ-008 SHALL assert issue_stall combinationally when issue_valid and any nonzero issue_ra, issue_rb, or (issue_we) issue_rw has its busy bit set (RAW and WAW).
REQ-009 SHALL hold at most one MDU result in a hold register (hold_rw, hold_wd); mdu_ready = 1 iff hold is empty.
REQ-010 SHALL give pipeline writes absolute priority: pipe_we & pipe_rw!=0 drives rf_we=1, rf_rw=pipe_rw, rf_busw=pipe_wd the same cycle (zero latency).
REQ-011 SHALL write the held result (rf_we=1, rf_rw=hold_rw, rf_busw=hold_wd) in any cycle with a full hold and no pipeline write, and empty the hold at the next edge.
REQ-012 SHALL never write r0; pipe_we with pipe_rw=0 gives rf_we=0 and frees the port for the hold.
REQ-013 SHALL implement hold FSM: EMPTY -> FULL on MDU accept; FULL -> EMPTY on drain; FULL -> STARVED when wait counter reaches STARVE_MAX; STARVED -> EMPTY on drain.
REQ-014 SHALL count consecutive FULL cycles lost to pipeline writes, saturating at STARVE_MAX, cleared on drain.
REQ-015 SHALL assert issue_stall in STARVED so pipeline bubbles reach WB and the hold drains.
REQ-016 SHALL allow a new MDU accept in the cycle after a drain, not in the drain cycle (one-cycle turnaround).
REQ-017 SHALL drive rf_we=0 and leave rf_rw/rf_busw don't-care when neither source writes.

Reset
REQ-018 SHALL on reset_n low asynchronously clear busy_mask, hold register, wait counter, FSM to EMPTY; outputs issue_stall=0 (with issue_valid=0), mdu_ready=1, rf_we=0.
REQ-019 SHALL discard an MDU result in the hold when reset asserts mid-operation; no register-file write follows reset release until a new source requests.

Configuration
REQ-020 SHALL implement the starvation guard (counter, STARVED state, REQ-015) only when macro RF_WB_STARVE_GUARD_EN is defined; without it, FSM has EMPTY/FULL only and the hold waits indefinitely for a free port.

Structure
REQ-021 SHALL place the hold-FSM state enum and DW/AW defaults in the shared CPU package.
REQ-022 SHALL instantiate one sub-module rf_scoreboard (busy_mask set/clear and RAW/WAW check); the hold and port mux stay in rf_wb_sched.

Verification
REQ-023 Long issue rw=5, then issue ra=5 -> issue_stall=1 until MDU result r5 written, busy_mask[5] clears same cycle the write appears on rf_*.
REQ-024 mdu_valid rw=7 wd=0xAAAA5555 with pipe_we=1 rw=3 same cycle -> rf writes r3 first, hold writes r7 next free cycle, mdu_ready=0 meanwhile.
REQ-025 Hold full, pipe_we=1 for 10 cycles, guard on -> issue_stall asserts after 4 lost cycles; guard off -> no stall, hold drains on first free cycle.
REQ-026 pipe_we=1 pipe_rw=0 with hold full -> rf_we=1 rf_rw=hold_rw; issue long rw=0 -> busy_mask unchanged.
REQ-027 reset_n low with hold full and busy_mask[9]=1 -> busy_mask=0, mdu_ready=1, rf_we=0 immediately, no write of r9 after release.
